// File: rtl/ccsds_align_pkg.sv
// ccsds_align_pkg: shared FSM state type, header geometry helpers and default parameters
// for the CCSDS header aligner.
package ccsds_align_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_HDR_W   = 48;
    localparam int DEF_LEN_W   = 16;
    localparam int DEF_LEN_LSB = 0;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    function automatic int hdr_words(input int dw, input int hw);
        return (hw + dw - 1) / dw;
    endfunction

    function automatic int hdr_ofs(input int dw, input int hw);
        return hw % dw;
    endfunction

    function automatic int res_w(input int dw, input int hw);
        return (hdr_ofs(dw, hw) == 0) ? 0 : dw - hdr_ofs(dw, hw);
    endfunction

endpackage

// File: rtl/ccsds_out_reg.sv
// ccsds_out_reg: single-entry valid/ready output register for payload data plus last flag;
// ready allows a load in the same cycle the held word is accepted.
module ccsds_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    input  logic              last,
    output logic              ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    assign ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= d;
            out_last  <= last;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ccsds_hdr_aligner.sv
// ccsds_hdr_aligner: strips an HDR_W-bit primary header and re-aligns the payload to DATA_W words.
// Optional HDR_ALIGN_STATS_EN adds pkt_count/err_count outputs.
module ccsds_hdr_aligner
    import ccsds_align_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int HDR_W   = DEF_HDR_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int LEN_LSB = DEF_LEN_LSB
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [HDR_W-1:0]  hdr_data,
    output logic              hdr_valid,
    output logic              err_sop
`ifdef HDR_ALIGN_STATS_EN
    ,
    output logic [15:0]       pkt_count,
    output logic [15:0]       err_count
`endif
);

    localparam int HW = hdr_words(DATA_W, HDR_W);
    localparam int RW = res_w(DATA_W, HDR_W);
    localparam int HB = HW * DATA_W;

    state_t            state, state_d;
    logic [HB-1:0]     hbuf, hshift;
    logic [HDR_W-1:0]  hdr_next;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] res, pay_data;
    logic [LEN_W:0]    rem;
    logic [2:0]        hcnt;
    logic              acc, sop_acc, hdr_done, pay_load, pay_last, oreg_ready;

    assign acc      = in_valid && in_ready;
    assign sop_acc  = acc && in_sop;
    assign in_ready = reset && (state != PAYLOAD || oreg_ready);
    assign hshift   = (hbuf << DATA_W) | HB'(in_data);
    assign hdr_next = hshift[HB-1 -: HDR_W];
    assign len      = hdr_next[LEN_LSB +: LEN_W];
    // The last header word supplies the leading RW bits of the first payload word.
    assign pay_data = DATA_W'({res, in_data} >> RW);

    always_comb begin
        state_d  = state;
        hdr_done = 1'b0;
        pay_load = 1'b0;
        pay_last = 1'b0;
        if (sop_acc) begin
            state_d  = (HW == 1) ? PAYLOAD : HDR;
            hdr_done = (HW == 1);
        end else if (acc && state == HDR && hcnt == 3'(HW - 1)) begin
            state_d  = PAYLOAD;
            hdr_done = 1'b1;
        end else if (acc && state == PAYLOAD) begin
            pay_load = 1'b1;
            pay_last = (rem == (LEN_W+1)'(1));
            state_d  = pay_last ? IDLE : PAYLOAD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            hbuf      <= '0;
            res       <= '0;
            hcnt      <= '0;
            rem       <= '0;
            hdr_data  <= '0;
            hdr_valid <= 1'b0;
            err_sop   <= 1'b0;
        end else begin
            state     <= state_d;
            hdr_valid <= hdr_done;
            err_sop   <= sop_acc && state != IDLE;
            if (acc) begin
                hbuf <= hshift;
                res  <= in_data;
            end
            if (sop_acc)
                hcnt <= 3'd1;
            else if (acc && state == HDR)
                hcnt <= hcnt + 3'd1;
            if (hdr_done) begin
                hdr_data <= hdr_next;
                rem      <= {1'b0, len} + (LEN_W+1)'(1);
            end else if (pay_load) begin
                rem <= rem - (LEN_W+1)'(1);
            end
        end
    end

    ccsds_out_reg #(.DATA_W(DATA_W)) u_oreg (
        .clk       (clk),
        .reset     (reset),
        .load      (pay_load),
        .d         (pay_data),
        .last      (pay_last),
        .ready     (oreg_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

`ifdef HDR_ALIGN_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_count <= '0;
            err_count <= '0;
        end else begin
            if (out_valid && out_ready && out_last)
                pkt_count <= pkt_count + 16'd1;
            if (err_sop)
                err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ccsds_hdr_aligner.sv
// tb_ccsds_hdr_aligner: directed vector tables, corner sequences and a randomized
// scoreboard run against a bit-stream reference model.
module tb_ccsds_hdr_aligner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] in_data, out_data;
    logic        in_valid, in_sop, in_ready, out_valid, out_last, out_ready;
    logic [47:0] hdr_data;
    logic        hdr_valid, err_sop;

    logic [15:0] a_in_data, a_out_data;
    logic        a_in_valid, a_in_sop, a_in_ready, a_out_valid, a_out_last, a_out_ready;
    logic [47:0] a_hdr_data;
    logic        a_hdr_valid, a_err_sop;
`ifdef HDR_ALIGN_STATS_EN
    logic [15:0] pkt_count, err_count, a_pkt_count, a_err_count;
`endif

    ccsds_hdr_aligner #(.DATA_W(32), .HDR_W(48), .LEN_W(16), .LEN_LSB(0)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .hdr_data(hdr_data), .hdr_valid(hdr_valid), .err_sop(err_sop)
`ifdef HDR_ALIGN_STATS_EN
        , .pkt_count(pkt_count), .err_count(err_count)
`endif
    );

    ccsds_hdr_aligner #(.DATA_W(16), .HDR_W(48), .LEN_W(4), .LEN_LSB(0)) dut16 (
        .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid), .in_sop(a_in_sop),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid), .out_last(a_out_last),
        .out_ready(a_out_ready), .hdr_data(a_hdr_data), .hdr_valid(a_hdr_valid), .err_sop(a_err_sop)
`ifdef HDR_ALIGN_STATS_EN
        , .pkt_count(a_pkt_count), .err_count(a_err_count)
`endif
    );

    localparam logic [31:0] D0 = 32'h0800_0000, D1 = 32'h0001_1111;
    localparam logic [31:0] D2 = 32'h2222_3333, D3 = 32'h4444_5555;
    localparam logic [47:0] H  = 48'h0800_0000_0001;

    typedef struct {
        logic v, s; logic [31:0] d; logic r;
        logic ir, ov; logic [31:0] od; logic ol, hv;
    } vec_t;
    typedef struct { logic [31:0] d; logic l; } out_t;

    vec_t        tbl[$];
    out_t        exp_q[$];
    logic [47:0] exp_h[$];
    logic [31:0] pkt[$];
    int          errors = 0, checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic v, s, input logic [31:0] d, input logic r, ir, ov,
                       input logic [31:0] od, input logic ol, hv);
        tbl.push_back('{v, s, d, r, ir, ov, od, ol, hv});
    endtask

    task automatic cyc(input logic v, s, input logic [31:0] d, input logic r);
        @(posedge clk); #1;
        in_valid = v; in_sop = s; in_data = d; out_ready = r;
        @(negedge clk);
    endtask

    task automatic cyc16(input logic v, s, input logic [15:0] d, input logic r);
        @(posedge clk); #1;
        a_in_valid = v; a_in_sop = s; a_in_data = d; a_out_ready = r;
        @(negedge clk);
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            cyc(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r);
            check($sformatf("vec%0d in_ready", i), in_ready, tbl[i].ir);
            check($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ov);
            check($sformatf("vec%0d hdr_valid", i), hdr_valid, tbl[i].hv);
            check($sformatf("vec%0d err_sop", i), err_sop, 0);
            if (tbl[i].ov) begin
                check($sformatf("vec%0d out_data", i), out_data, tbl[i].od);
                check($sformatf("vec%0d out_last", i), out_last, tbl[i].ol);
            end
            if (tbl[i].hv) check($sformatf("vec%0d hdr_data", i), hdr_data, H);
        end
    endtask

    // Reference: the packet is one MSB-first bit stream; header = first 48 bits,
    // then N = len+1 consecutive 32-bit payload words, the remainder is discarded.
    function automatic void model();
        bit          b[$];
        logic [47:0] h = '0;
        out_t        o;
        int          n;
        foreach (pkt[i]) for (int k = 31; k >= 0; k--) b.push_back(pkt[i][k]);
        for (int i = 0; i < 48; i++) h = {h[46:0], b[i]};
        exp_h.push_back(h);
        n = int'(h[15:0]) + 1;
        for (int j = 0; j < n; j++) begin
            o.d = '0;
            for (int k = 0; k < 32; k++) o.d = {o.d[30:0], b[48 + 32*j + k]};
            o.l = (j == n - 1);
            exp_q.push_back(o);
        end
    endfunction

    task automatic mon();
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_out_extra", out_valid, 0);
            else begin
                check("sb_out_data", out_data, exp_q[0].d);
                check("sb_out_last", out_last, exp_q[0].l);
                void'(exp_q.pop_front());
            end
        end
        if (hdr_valid) begin
            if (exp_h.size() == 0) check("sb_hdr_extra", hdr_valid, 0);
            else begin
                check("sb_hdr_data", hdr_data, exp_h[0]);
                void'(exp_h.pop_front());
            end
        end
    endtask

    task automatic rstep(input logic v, s, input logic [31:0] d, input logic force_rdy);
        @(posedge clk); #1;
        in_valid = v; in_sop = s; in_data = d;
        out_ready = force_rdy || ($urandom_range(0, 3) != 0);
        @(negedge clk);
        mon();
    endtask

    task automatic send(input logic [31:0] d, input logic s);
        int n = 0;
        rstep(1'b1, s, d, 1'b0);
        while (!in_ready && n < 100) begin
            rstep(1'b1, s, d, 1'b0);
            n++;
        end
        if (n == 100) check("send_ready_timeout", in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // basic packet (0..5)
        add(1,1,D0,1, 1,0,0,0,0); add(1,0,D1,1, 1,0,0,0,0); add(1,0,D2,1, 1,0,0,0,1);
        add(1,0,D3,1, 1,1,32'h1111_2222,0,0); add(0,0,0,1, 1,1,32'h3333_4444,1,0);
        add(0,0,0,1, 1,0,0,0,0);
        // backpressure (6..13)
        add(1,1,D0,1, 1,0,0,0,0); add(1,0,D1,1, 1,0,0,0,0); add(1,0,D2,1, 1,0,0,0,1);
        add(1,0,D3,0, 0,1,32'h1111_2222,0,0); add(1,0,D3,0, 0,1,32'h1111_2222,0,0);
        add(1,0,D3,1, 1,1,32'h1111_2222,0,0); add(0,0,0,1, 1,1,32'h3333_4444,1,0);
        add(0,0,0,1, 1,0,0,0,0);
        // noise then basic packet (14..22)
        add(1,0,32'hDEAD_BEEF,1, 1,0,0,0,0); add(1,0,32'h1234_5678,1, 1,0,0,0,0);
        add(1,0,32'hCAFE_F00D,1, 1,0,0,0,0);
        for (int i = 0; i < 6; i++) tbl.push_back(tbl[i]);

        reset = 1'b0;
        {in_valid, in_sop, in_data, out_ready} = '0;
        {a_in_valid, a_in_sop, a_in_data, a_out_ready} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 0);
        check("rst hdr_valid", hdr_valid, 0);
        check("rst hdr_data", hdr_data, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("idle in_ready", in_ready, 1);
        check("idle out_valid", out_valid, 0);

        run_table(0, 6);
        run_table(6, 14);
        run_table(14, 23);

        // abort: new sop after the first payload word
        cyc(1,1,D0,1); cyc(1,0,D1,1); cyc(1,0,D2,1);
        check("abort hdr_valid1", hdr_valid, 1);
        cyc(1,1,32'h1234_5678,1);
        check("abort pend valid", out_valid, 1);
        check("abort pend data", out_data, 32'h1111_2222);
        check("abort pend last", out_last, 0);
        check("abort in_ready", in_ready, 1);
        cyc(1,0,32'h0000_AAAA,1);
        check("abort err_sop", err_sop, 1);
        check("abort truncated", out_valid, 0);
        cyc(1,0,32'hBBBB_CCCC,1);
        check("abort hdr_valid2", hdr_valid, 1);
        check("abort hdr_data2", hdr_data, 48'h1234_5678_0000);
        check("abort err_sop off", err_sop, 0);
        cyc(0,0,0,1);
        check("abort p2 valid", out_valid, 1);
        check("abort p2 data", out_data, 32'hAAAA_BBBB);
        check("abort p2 last", out_last, 1);
        cyc(0,0,0,1);
        check("abort p2 done", out_valid, 0);
`ifdef HDR_ALIGN_STATS_EN
        check("stats err_count", err_count, 1);
        check("stats pkt_count", pkt_count, 4);
`endif

        // asynchronous reset while an output word is stalled
        cyc(1,1,D0,0); cyc(1,0,D1,0); cyc(1,0,D2,0); cyc(1,0,D3,0);
        check("mid stalled valid", out_valid, 1);
        check("mid stalled ready", in_ready, 0);
        #1 reset = 1'b0;
        #1;
        check("mid rst out_valid", out_valid, 0);
        check("mid rst hdr_data", hdr_data, 0);
        check("mid rst in_ready", in_ready, 0);
        @(posedge clk); #1 reset = 1'b1;
        cyc(0,0,0,1);
        check("post rst out_valid", out_valid, 0);
        check("post rst in_ready", in_ready, 1);
        run_table(0, 6);

        // aligned 16/48, length 0: one word passed unchanged
        cyc16(1,1,16'h0A0B,1);
        check("a16 in_ready", a_in_ready, 1);
        cyc16(1,0,16'hC0D0,1);
        check("a16 hv early1", a_hdr_valid, 0);
        cyc16(1,0,16'h0000,1);
        check("a16 hv early2", a_hdr_valid, 0);
        cyc16(1,0,16'hBEEF,1);
        check("a16 hdr_valid", a_hdr_valid, 1);
        check("a16 hdr_data", a_hdr_data, 48'h0A0B_C0D0_0000);
        check("a16 no early out", a_out_valid, 0);
        cyc16(0,0,0,1);
        check("a16 out_valid", a_out_valid, 1);
        check("a16 out_data", a_out_data, 16'hBEEF);
        check("a16 out_last", a_out_last, 1);
        cyc16(0,0,0,1);
        check("a16 done", a_out_valid, 0);
`ifdef HDR_ALIGN_STATS_EN
        check("a16 pkt_count", a_pkt_count, 1);
`endif

        // aligned 16/48 with maximum 4-bit length field: 16 words, last only on the 16th
        cyc16(1,1,16'h1111,1); cyc16(1,0,16'h2222,1); cyc16(1,0,16'h000F,1);
        for (int k = 0; k <= 16; k++) begin
            cyc16(k < 16, 0, 16'h1000 + 16'(k), 1);
            if (k == 0) check("max hdr_data", a_hdr_data, 48'h1111_2222_000F);
            else begin
                check($sformatf("max w%0d valid", k), a_out_valid, 1);
                check($sformatf("max w%0d data", k), a_out_data, 16'h1000 + 16'(k - 1));
                check($sformatf("max w%0d last", k), a_out_last, k == 16);
            end
        end
        cyc16(0,0,0,1);
        check("max done", a_out_valid, 0);

        // randomized packets against the bit-stream model
        for (int p = 0; p < 40; p++) begin
            int nl;
            for (int j = $urandom_range(0, 2); j > 0; j--) send($urandom, 1'b0);
            if ($urandom_range(0, 1) != 0) rstep(0, 0, 0, 1'b0);
            nl = $urandom_range(0, 5);
            pkt.delete();
            pkt.push_back($urandom);
            pkt.push_back({16'(nl), 16'($urandom)});
            for (int j = 0; j <= nl; j++) pkt.push_back($urandom);
            model();
            foreach (pkt[i]) begin
                send(pkt[i], i == 0);
                if ($urandom_range(0, 4) == 0) rstep(0, 0, 0, 1'b0);
            end
        end
        for (int n = 0; n < 50 && (exp_q.size() != 0 || exp_h.size() != 0); n++)
            rstep(0, 0, 0, 1'b1);
        check("sb_out_left", exp_q.size(), 0);
        check("sb_hdr_left", exp_h.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
